trap_ctrl: RTL and testbench

- Trap controller at the commit point of the RV32 pipeline; drives the trap side of the CSR register file.
- Samples synchronous exceptions, xRET requests and raw interrupt lines, prioritises them against CSR enable outputs, and issues a one-cycle trap/return pulse: exception_pending, m_cause, pc_exc, m_ret/s_ret.
- Holds a pipeline flush until the frontend accepts the redirect to the epc the CSR file computes.

---
 rtl/trap_ctrl.sv | 154 +++++++++++++++
 tb/tb_trap_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap controller at the commit point: prioritises interrupts, exceptions and xRET,
// issues a one-cycle trap/return pulse to the CSR file and holds flush until fetch redirects.
module trap_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned XLEN        = 32
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            stall,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] pc_commit,
   input  logic            exc_valid,
   input  logic [4:0]      exc_code,
   input  logic            mret_req,
   input  logic            sret_req,
   input  logic            mem_busy,
   input  logic            m_eie,
   input  logic            m_tie,
   input  logic            s_eie,
   input  logic            s_tie,
   input  logic            m_ext_irq,
   input  logic            s_ext_irq,
   input  logic            m_timer,
   input  logic            s_timer,
   input  logic            fetch_ready,
   output logic            exception_pending,
   output logic [XLEN-1:0] m_cause,
   output logic [XLEN-1:0] pc_exc,
   output logic            m_ret,
   output logic            s_ret,
   output logic            flush
);

   typedef enum logic [1:0] {StIdle, StWaitMem, StTrap, StRedirect} state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] m_sync_q, s_sync_q;
   logic [XLEN-1:0]        pc_q, pc_d;

   logic            pend_q, pend_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] pc_exc_q, pc_exc_d;
   logic            m_ret_q, m_ret_d;
   logic            s_ret_q, s_ret_d;
   logic            flush_q, flush_d;

   logic       mei, mti, sei, sti, irq_any;
   logic [4:0] irq_code;

   function automatic logic [XLEN-1:0] mk_cause(input logic intr, input logic [4:0] code);
      return {intr, {(XLEN-6){1'b0}}, code};
   endfunction

   assign mei     = m_sync_q[SYNC_STAGES-1] & m_eie;
   assign mti     = m_timer & m_tie;
   assign sei     = s_sync_q[SYNC_STAGES-1] & s_eie;
   assign sti     = s_timer & s_tie;
   assign irq_any = mei | mti | sei | sti;

   // Machine-level sources outrank supervisor ones; external outranks timer within a level.
   always_comb begin
      irq_code = 5'd0;
      if (mei)      irq_code = 5'd11;
      else if (mti) irq_code = 5'd7;
      else if (sei) irq_code = 5'd9;
      else if (sti) irq_code = 5'd5;
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pend_d   = 1'b0;
      cause_d  = '0;
      pc_exc_d = '0;
      m_ret_d  = 1'b0;
      s_ret_d  = 1'b0;
      flush_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (instr_valid && !stall) begin
               pc_d = pc_commit;
               if (irq_any && mem_busy) begin
                  state_d = StWaitMem;
               end else if (irq_any || exc_valid || mret_req || sret_req) begin
                  state_d  = StTrap;
                  pend_d   = 1'b1;
                  flush_d  = 1'b1;
                  pc_exc_d = pc_commit;
                  if (irq_any)        cause_d = mk_cause(1'b1, irq_code);
                  else if (exc_valid) cause_d = mk_cause(1'b0, exc_code);
                  else if (mret_req)  m_ret_d = 1'b1;
                  else                s_ret_d = 1'b1;
               end
            end
         end
         StWaitMem: begin
            // Interrupts are level: if the source goes away while waiting, drop it silently.
            if (!irq_any) begin
               state_d = StIdle;
            end else if (!mem_busy) begin
               state_d  = StTrap;
               pend_d   = 1'b1;
               flush_d  = 1'b1;
               pc_exc_d = pc_q;
               cause_d  = mk_cause(1'b1, irq_code);
            end
         end
         StTrap: begin
            state_d = StRedirect;
            flush_d = 1'b1;
         end
         StRedirect: begin
            if (fetch_ready) state_d = StIdle;
            else             flush_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= StIdle;
         m_sync_q <= '0;
         s_sync_q <= '0;
         pc_q     <= '0;
         pend_q   <= 1'b0;
         cause_q  <= '0;
         pc_exc_q <= '0;
         m_ret_q  <= 1'b0;
         s_ret_q  <= 1'b0;
         flush_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_sync_q <= {m_sync_q[SYNC_STAGES-2:0], m_ext_irq};
         s_sync_q <= {s_sync_q[SYNC_STAGES-2:0], s_ext_irq};
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         cause_q  <= cause_d;
         pc_exc_q <= pc_exc_d;
         m_ret_q  <= m_ret_d;
         s_ret_q  <= s_ret_d;
         flush_q  <= flush_d;
      end
   end

   assign exception_pending = pend_q;
   assign m_cause           = cause_q;
   assign pc_exc            = pc_exc_q;
   assign m_ret             = m_ret_q;
   assign s_ret             = s_ret_q;
   assign flush             = flush_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: table of single-event vectors, directed multi-cycle sequences,
// then randomized traffic checked against a transaction-level reference model.
module tb_trap_ctrl;

   localparam int unsigned SYNC = 2;

   logic        clk = 1'b0;
   logic        nrst, stall, instr_valid, exc_valid, mret_req, sret_req, mem_busy;
   logic        m_eie, m_tie, s_eie, s_tie, m_ext_irq, s_ext_irq, m_timer, s_timer;
   logic        fetch_ready;
   logic [31:0] pc_commit;
   logic [4:0]  exc_code;
   logic        exception_pending, m_ret, s_ret, flush;
   logic [31:0] m_cause, pc_exc;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.SYNC_STAGES(SYNC), .XLEN(32)) dut (
      .clk(clk), .nrst(nrst), .stall(stall), .instr_valid(instr_valid),
      .pc_commit(pc_commit), .exc_valid(exc_valid), .exc_code(exc_code),
      .mret_req(mret_req), .sret_req(sret_req), .mem_busy(mem_busy),
      .m_eie(m_eie), .m_tie(m_tie), .s_eie(s_eie), .s_tie(s_tie),
      .m_ext_irq(m_ext_irq), .s_ext_irq(s_ext_irq), .m_timer(m_timer), .s_timer(s_timer),
      .fetch_ready(fetch_ready), .exception_pending(exception_pending), .m_cause(m_cause),
      .pc_exc(pc_exc), .m_ret(m_ret), .s_ret(s_ret), .flush(flush)
   );

   typedef struct {
      bit          exc;
      logic [4:0]  code;
      bit          mret;
      bit          sret;
      bit          mtim;
      bit          mtie;
      bit          stim;
      bit          stie;
      logic [31:0] pc;
      logic [31:0] ecause;
      bit          emret;
      bit          esret;
   } vec_t;

   vec_t tbl[10];

   // Reference model state: sync delay lines plus a description of the trap in progress.
   bit          m_q[$];
   bit          s_q[$];
   int          irq_code[4] = '{11, 7, 9, 5};
   bit          mo_pulse, mo_redir, mo_def;
   logic [31:0] def_pc;
   bit          e_pend, e_mret, e_sret, e_flush;
   logic [31:0] e_cause, e_pc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input bit p, input logic [31:0] c, input logic [31:0] pc,
                      input bit mr, input bit sr, input bit fl);
      n_vec++;
      if (exception_pending !== p || m_cause !== c || pc_exc !== pc || m_ret !== mr ||
          s_ret !== sr || flush !== fl) begin
         n_bad++;
         $display("FAIL %s: got pend=%0b cause=%h pc=%h mret=%0b sret=%0b flush=%0b, want pend=%0b cause=%h pc=%h mret=%0b sret=%0b flush=%0b",
                  name, exception_pending, m_cause, pc_exc, m_ret, s_ret, flush,
                  p, c, pc, mr, sr, fl);
      end
   endtask

   task automatic chk_idle(input string name);
      chk(name, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_flush(input string name);
      chk(name, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic clear_inputs();
      stall = 0; instr_valid = 0; exc_valid = 0; exc_code = 0; mret_req = 0; sret_req = 0;
      mem_busy = 0; m_eie = 0; m_tie = 0; s_eie = 0; s_tie = 0; m_ext_irq = 0; s_ext_irq = 0;
      m_timer = 0; s_timer = 0; fetch_ready = 0; pc_commit = 0;
   endtask

   // Finish a trap whose pulse cycle was just checked: one redirect cycle, then idle.
   task automatic drain();
      instr_valid = 0; exc_valid = 0; mret_req = 0; sret_req = 0; fetch_ready = 1;
      tick(); chk_flush("redirect");
      tick(); chk_idle("back_idle");
      fetch_ready = 0;
   endtask

   task automatic fire(input bit intr, input logic [4:0] code, input logic [31:0] pc,
                       input bit mr, input bit sr);
      e_pend  = 1;
      e_flush = 1;
      e_cause = (mr || sr) ? 32'h0 : {intr, 26'b0, code};
      e_pc    = pc;
      e_mret  = mr;
      e_sret  = sr;
      mo_pulse = 1;
   endtask

   // Expected outputs after the coming clock edge, from the current inputs.
   task automatic model_step();
      bit ms, ss, hit;
      bit pend[4];
      int code;
      ms = m_q[0]; void'(m_q.pop_front()); m_q.push_back(m_ext_irq);
      ss = s_q[0]; void'(s_q.pop_front()); s_q.push_back(s_ext_irq);
      pend[0] = ms & m_eie;
      pend[1] = m_timer & m_tie;
      pend[2] = ss & s_eie;
      pend[3] = s_timer & s_tie;
      hit = 0; code = 0;
      for (int i = 0; i < 4; i++) begin
         if (pend[i] && !hit) begin
            hit = 1;
            code = irq_code[i];
         end
      end
      e_pend = 0; e_cause = 0; e_pc = 0; e_mret = 0; e_sret = 0; e_flush = 0;
      if (mo_pulse) begin
         mo_pulse = 0;
         mo_redir = 1;
         e_flush  = 1;
      end else if (mo_redir) begin
         if (fetch_ready) mo_redir = 0;
         else             e_flush = 1;
      end else if (mo_def) begin
         if (!hit) begin
            mo_def = 0;
         end else if (!mem_busy) begin
            mo_def = 0;
            fire(1'b1, code[4:0], def_pc, 1'b0, 1'b0);
         end
      end else if (instr_valid && !stall) begin
         if (hit && mem_busy) begin
            mo_def = 1;
            def_pc = pc_commit;
         end else if (hit)     fire(1'b1, code[4:0], pc_commit, 1'b0, 1'b0);
         else if (exc_valid)   fire(1'b0, exc_code, pc_commit, 1'b0, 1'b0);
         else if (mret_req)    fire(1'b0, 5'd0, pc_commit, 1'b1, 1'b0);
         else if (sret_req)    fire(1'b0, 5'd0, pc_commit, 1'b0, 1'b1);
      end
   endtask

   initial begin
      tbl[0] = '{1, 5'd2,  0, 0, 0, 0, 0, 0, 32'h104, 32'h0000_0002, 0, 0};
      tbl[1] = '{1, 5'd31, 0, 0, 0, 0, 0, 0, 32'h010, 32'h0000_001F, 0, 0};
      tbl[2] = '{0, 5'd0,  1, 0, 0, 0, 0, 0, 32'h300, 32'h0000_0000, 1, 0};
      tbl[3] = '{0, 5'd0,  0, 1, 0, 0, 0, 0, 32'h304, 32'h0000_0000, 0, 1};
      tbl[4] = '{0, 5'd0,  0, 0, 1, 1, 0, 0, 32'h200, 32'h8000_0007, 0, 0};
      tbl[5] = '{1, 5'd5,  0, 0, 1, 1, 0, 0, 32'h204, 32'h8000_0007, 0, 0};
      tbl[6] = '{0, 5'd0,  0, 0, 0, 0, 1, 1, 32'h203, 32'h8000_0005, 0, 0};
      tbl[7] = '{0, 5'd0,  0, 0, 1, 0, 1, 1, 32'h20C, 32'h8000_0005, 0, 0};
      tbl[8] = '{1, 5'd13, 1, 0, 0, 0, 0, 0, 32'h401, 32'h0000_000D, 0, 0};
      tbl[9] = '{0, 5'd0,  1, 1, 0, 0, 0, 0, 32'h402, 32'h0000_0000, 1, 0};

      clear_inputs();
      nrst = 0;
      tick(); tick();
      chk_idle("reset");
      nrst = 1;

      foreach (tbl[i]) begin
         instr_valid = 1; exc_valid = tbl[i].exc; exc_code = tbl[i].code;
         mret_req = tbl[i].mret; sret_req = tbl[i].sret; m_timer = tbl[i].mtim;
         m_tie = tbl[i].mtie; s_timer = tbl[i].stim; s_tie = tbl[i].stie; pc_commit = tbl[i].pc;
         tick();
         chk($sformatf("tbl%0d", i), 1'b1, tbl[i].ecause, tbl[i].pc, tbl[i].emret,
             tbl[i].esret, 1'b1);
         clear_inputs();
         drain();
      end

      // Flush held while the frontend is not ready.
      instr_valid = 1; exc_valid = 1; exc_code = 2; pc_commit = 32'h104;
      tick(); chk("exc_hold", 1, 32'h2, 32'h104, 0, 0, 1);
      clear_inputs();
      repeat (3) begin tick(); chk_flush("hold_flush"); end
      fetch_ready = 1;
      tick(); chk_idle("flush_release");
      fetch_ready = 0;

      // Synchronized SEI outranked by MTI, then taken alone.
      s_ext_irq = 1; s_eie = 1;
      tick(); chk_idle("sei_sync1");
      tick(); chk_idle("sei_sync2");
      m_timer = 1; m_tie = 1; instr_valid = 1; pc_commit = 32'h200;
      tick(); chk("mti_over_sei", 1, 32'h8000_0007, 32'h200, 0, 0, 1);
      m_timer = 0; m_tie = 0;
      drain();
      instr_valid = 1; pc_commit = 32'h208;
      tick(); chk("sei", 1, 32'h8000_0009, 32'h208, 0, 0, 1);
      s_ext_irq = 0; s_eie = 0;
      drain();

      // MEI visible only after the synchronizer depth.
      m_ext_irq = 1; m_eie = 1; instr_valid = 1; pc_commit = 32'h0C;
      tick(); chk_idle("mei_sync1");
      tick(); chk_idle("mei_sync2");
      tick(); chk("mei", 1, 32'h8000_000B, 32'h0C, 0, 0, 1);
      drain();

      // MEI deferred behind outstanding memory, with latched pc.
      instr_valid = 1; mem_busy = 1; pc_commit = 32'h400;
      tick(); chk_idle("wait_mem1");
      pc_commit = 32'h999;
      repeat (3) begin tick(); chk_idle("wait_mem"); end
      mem_busy = 0;
      tick(); chk("mei_after_mem", 1, 32'h8000_000B, 32'h400, 0, 0, 1);
      drain();

      // Enable dropped while waiting: no trap ever.
      instr_valid = 1; mem_busy = 1; pc_commit = 32'h404;
      tick(); chk_idle("wait_drop1");
      instr_valid = 0; m_eie = 0;
      tick(); chk_idle("wait_drop2");
      mem_busy = 0;
      repeat (3) begin tick(); chk_idle("dropped"); end
      m_ext_irq = 0;
      instr_valid = 1; exc_valid = 1; exc_code = 4; pc_commit = 32'h408;
      tick(); chk("exc_after_drop", 1, 32'h4, 32'h408, 0, 0, 1);
      drain();

      // Stall and invalid instruction suppress sampling.
      instr_valid = 1; exc_valid = 1; exc_code = 6; stall = 1; pc_commit = 32'h600;
      repeat (5) begin tick(); chk_idle("stalled"); end
      stall = 0;
      tick(); chk("unstall", 1, 32'h6, 32'h600, 0, 0, 1);
      drain();
      instr_valid = 0; exc_valid = 1;
      repeat (2) begin tick(); chk_idle("no_valid"); end
      clear_inputs();

      // Reset in the middle of a redirect.
      instr_valid = 1; exc_valid = 1; exc_code = 1; pc_commit = 32'h700;
      tick(); chk("exc_pre_rst", 1, 32'h1, 32'h700, 0, 0, 1);
      clear_inputs();
      tick(); chk_flush("redirect_pre_rst");
      nrst = 0;
      tick(); chk_idle("rst_mid_redirect");
      nrst = 1;
      instr_valid = 1; exc_valid = 1; exc_code = 3; pc_commit = 32'h500;
      tick(); chk("exc_post_rst", 1, 32'h3, 32'h500, 0, 0, 1);
      drain();

      // Randomized traffic against the reference model.
      clear_inputs();
      nrst = 0;
      tick(); tick();
      m_q.delete(); s_q.delete();
      repeat (SYNC) begin m_q.push_back(1'b0); s_q.push_back(1'b0); end
      mo_pulse = 0; mo_redir = 0; mo_def = 0; def_pc = 0;
      nrst = 1;
      for (int n = 0; n < 800; n++) begin
         instr_valid = ($urandom_range(0, 3) != 0);
         stall       = ($urandom_range(0, 4) == 0);
         exc_valid   = ($urandom_range(0, 4) == 0);
         exc_code    = 5'($urandom_range(0, 31));
         mret_req    = ($urandom_range(0, 7) == 0);
         sret_req    = ($urandom_range(0, 7) == 0);
         mem_busy    = ($urandom_range(0, 1) == 0);
         fetch_ready = ($urandom_range(0, 1) == 0);
         pc_commit   = $urandom;
         if ($urandom_range(0, 9) == 0) m_eie = ~m_eie;
         if ($urandom_range(0, 9) == 0) s_eie = ~s_eie;
         if ($urandom_range(0, 9) == 0) m_tie = ~m_tie;
         if ($urandom_range(0, 9) == 0) s_tie = ~s_tie;
         if ($urandom_range(0, 7) == 0) m_ext_irq = ~m_ext_irq;
         if ($urandom_range(0, 7) == 0) s_ext_irq = ~s_ext_irq;
         m_timer = ($urandom_range(0, 5) == 0);
         s_timer = ($urandom_range(0, 5) == 0);
         model_step();
         tick();
         chk("rand", e_pend, e_cause, e_pc, e_mret, e_sret, e_flush);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
